// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment-on patterns (abcdefg, bit 6 = a),
// idle anode value and the capture state encoding.
package seven_seg_pkg;

   localparam logic [6:0] SEG_PATTERNS [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   localparam logic [6:0] BLANK_PATTERN = 7'h00;
   localparam logic [3:0] ANODE_IDLE    = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SETTLING,
      CAPTURED
   } cap_state_t;

endpackage

// File: rtl/seven_segment_capture_seg_decode.sv
// segDecode: maps an active-high segment pattern back to its hex nibble,
// flagging whether the pattern is a legal digit or fully blank.
module segDecode
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal,
   output logic       blank
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG_PATTERNS[i]) begin
            nibble = 4'(i);
            legal  = 1'b1;
         end
      end
      blank = (pattern == BLANK_PATTERN);
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive-side monitor for the multiplexed four-digit display: waits for each
// anode strobe to settle, decodes it and latches the nibble per digit.
//
// state    | meaning
// IDLE     | all anodes high, waiting for a strobe
// SETTLING | pins changed, counting stable cycles up to SETTLE
// CAPTURED | strobe sampled once, holding until the pins change
module seven_segment_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] anode,
   input  logic [6:0] LEDOutput,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digitValid,
   output logic       frameValid,
   output logic       decodeError,
   output logic       anodeError
);

   localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

   cap_state_t state, state_next;
   logic [3:0] prevAnode;
   logic [6:0] prevLED;
   logic [7:0] stableCount;
   logic [3:0] capturedMask;
   logic [3:0] digits [4];

   logic       changed;
   logic       act;
   logic [3:0] sel;
   logic       single;
   logic [1:0] idx;
   logic [3:0] mask_next;
   logic [3:0] nibble;
   logic       legal;
   logic       blank;

   assign changed   = ({anode, LEDOutput} != {prevAnode, prevLED});
   assign sel       = ~prevAnode;
   assign single    = $onehot(sel);
   assign mask_next = capturedMask | sel;

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) idx = 2'(i);
      end
   end

   segDecode u_seg_decode (
      .pattern (~prevLED),
      .nibble  (nibble),
      .legal   (legal),
      .blank   (blank)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A sample is taken only when the pins are still stable on the acting edge.
   always_comb begin
      state_next = state;
      act        = 1'b0;
      if (anode == ANODE_IDLE) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (changed) state_next = SETTLING;
            SETTLING: if (!changed && stableCount == SETTLE_CNT) begin
                         act        = 1'b1;
                         state_next = CAPTURED;
                      end
            CAPTURED: if (changed) state_next = SETTLING;
            default:  state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prevAnode    <= ANODE_IDLE;
         prevLED      <= 7'h7F;
         stableCount  <= 8'd0;
         capturedMask <= 4'h0;
         digitValid   <= 4'h0;
         frameValid   <= 1'b0;
         decodeError  <= 1'b0;
         anodeError   <= 1'b0;
         for (int i = 0; i < 4; i++) digits[i] <= 4'h0;
      end else begin
         prevAnode  <= anode;
         prevLED    <= LEDOutput;
         frameValid <= 1'b0;
         if (changed)                  stableCount <= 8'd0;
         else if (stableCount != 8'hFF) stableCount <= stableCount + 8'd1;

         if (act) begin
            if (single) begin
               if (legal) begin
                  digits[idx]     <= nibble;
                  digitValid[idx] <= 1'b1;
               end else begin
                  digitValid[idx] <= 1'b0;
                  if (!blank) decodeError <= 1'b1;
               end
               // The completing digit seeds the next frame's mask.
               if (mask_next == 4'hF) begin
                  frameValid   <= 1'b1;
                  capturedMask <= sel;
               end else begin
                  capturedMask <= mask_next;
               end
            end else begin
               anodeError <= 1'b1;
            end
         end
      end
   end

   assign digit0 = digits[0];
   assign digit1 = digits[1];
   assign digit2 = digits[2];
   assign digit3 = digits[3];

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with SETTLE=4.
module tb_seven_segment_capture;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] anode;
   logic [6:0] LEDOutput;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic [3:0] digitValid;
   logic       frameValid;
   logic       decodeError;
   logic       anodeError;

   int tests = 0;
   int fails = 0;
   int fv_count = 0;
   int fv_base;

   seven_segment_capture #(.SETTLE(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .anode       (anode),
      .LEDOutput   (LEDOutput),
      .digit0      (digit0),
      .digit1      (digit1),
      .digit2      (digit2),
      .digit3      (digit3),
      .digitValid  (digitValid),
      .frameValid  (frameValid),
      .decodeError (decodeError),
      .anodeError  (anodeError)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (frameValid === 1'b1) fv_count++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg_on);
      anode     = an;
      LEDOutput = ~seg_on;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_d0"}, 32'(digit0), 32'h0);
      check({tag, "_d1"}, 32'(digit1), 32'h0);
      check({tag, "_d2"}, 32'(digit2), 32'h0);
      check({tag, "_d3"}, 32'(digit3), 32'h0);
      check({tag, "_valid"}, 32'(digitValid), 32'h0);
      check({tag, "_fv"}, 32'(frameValid), 32'h0);
      check({tag, "_derr"}, 32'(decodeError), 32'h0);
      check({tag, "_aerr"}, 32'(anodeError), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      drive(4'hF, 7'h00);
      step(2);
      check_cleared("reset");
      reset = 1'b0;
      step(1);

      // Single strobe: digit 0 shows '2'; capture lands on the 6th edge (E0+5)
      drive(4'b1110, 7'h6D);
      step(5);
      check("t1_before_valid", 32'(digitValid), 32'h0);
      check("t1_before_d0", 32'(digit0), 32'h0);
      step(1);
      check("t1_d0", 32'(digit0), 32'h2);
      check("t1_valid", 32'(digitValid), 32'h1);
      step(4);
      check("t1_d0_hold", 32'(digit0), 32'h2);
      check("t1_no_frame", 32'(fv_count), 32'h0);

      // Full frame 1,2,3,4 across digits 0..3
      fv_base = fv_count;
      drive(4'b1110, 7'h30); step(8);
      drive(4'b1101, 7'h6D); step(8);
      drive(4'b1011, 7'h79); step(8);
      check("frame_no_early_pulse", 32'(fv_count - fv_base), 32'h0);
      drive(4'b0111, 7'h33);
      step(5);
      check("frame_fv_pre", 32'(frameValid), 32'h0);
      step(1);
      check("frame_fv_pulse", 32'(frameValid), 32'h1);
      check("frame_d3_same_cycle", 32'(digit3), 32'h4);
      step(1);
      check("frame_fv_drop", 32'(frameValid), 32'h0);
      step(1);
      check("frame_pulse_count", 32'(fv_count - fv_base), 32'h1);
      check("frame_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h4321);
      check("frame_valid", 32'(digitValid), 32'hF);

      // Short segment glitch while digit 0 is held at '8'
      drive(4'b1110, 7'h7F); step(8);
      check("glitch_d0_settled", 32'(digit0), 32'h8);
      drive(4'b1110, 7'h30); step(2);
      check("glitch_d0_during", 32'(digit0), 32'h8);
      drive(4'b1110, 7'h7F); step(3);
      check("glitch_d0_after", 32'(digit0), 32'h8);
      step(5);
      check("glitch_d0_final", 32'(digit0), 32'h8);

      // Blank then illegal pattern on digit 1
      drive(4'b1101, 7'h00); step(8);
      check("blank_no_error", 32'(decodeError), 32'h0);
      check("blank_valid1", 32'(digitValid[1]), 32'h0);
      check("blank_d1_kept", 32'(digit1), 32'h2);
      drive(4'b1101, 7'h01); step(8);
      check("illegal_error", 32'(decodeError), 32'h1);
      check("illegal_valid", 32'(digitValid), 32'hD);
      check("illegal_d1_kept", 32'(digit1), 32'h2);

      // Two anodes low: error only, no digit or mask change
      fv_base = fv_count;
      drive(4'b1100, 7'h7E); step(6);
      check("anode_err", 32'(anodeError), 32'h1);
      check("anode_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h4328);
      check("anode_valid", 32'(digitValid), 32'hD);
      drive(4'b1010, 7'h7E); step(6);
      check("anode_no_frame", 32'(fv_count - fv_base), 32'h0);
      // Digit 2 is the only missing mask bit, so 'A' completes a frame
      drive(4'b1011, 7'h77);
      step(5);
      check("mask_fv_pre", 32'(frameValid), 32'h0);
      step(1);
      check("mask_fv_pulse", 32'(frameValid), 32'h1);
      check("mask_d2", 32'(digit2), 32'hA);
      check("anode_err_sticky", 32'(anodeError), 32'h1);
      check("decode_err_sticky", 32'(decodeError), 32'h1);
      step(2);

      // Reset during a settling strobe
      drive(4'b0111, 7'h4E);
      step(2);
      reset = 1'b1;
      #1;
      check_cleared("midreset");
      step(2);
      reset = 1'b0;
      step(5);
      check("postreset_no_capture", 32'(digitValid), 32'h0);
      check("postreset_d3_zero", 32'(digit3), 32'h0);
      step(1);
      check("postreset_d3", 32'(digit3), 32'hC);
      check("postreset_valid", 32'(digitValid), 32'h8);
      check("postreset_errs", {30'h0, decodeError, anodeError}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
